// File: rtl/serial_parallel_rx.sv
// serial_parallel_rx
// Recovers bytes from a 1-bit MSB-first stream in the clk_32f domain.
// It searches for the comma idle symbol at any bit offset. It then confirms
// byte alignment over BC_COUNT consecutive boundary commas. Once locked, it
// presents every non-comma byte on data_out with valid_out for one byte time.

module serial_parallel_rx #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BCW = $clog2(BC_COUNT + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;

  logic [7:0]     shreg_r;
  logic [2:0]     bit_cnt_r;
  logic [2:0]     bit_cnt_nxt_s;
  logic [BCW-1:0] bc_cnt_r;
  logic [BCW-1:0] bc_cnt_nxt_s;
  logic [BCW-1:0] bc_inc_s;

  logic [7:0]     data_out_r;
  logic           valid_out_r;
  logic           active_r;
  logic [7:0]     data_out_nxt_s;
  logic           valid_out_nxt_s;
  logic           active_nxt_s;

  logic [7:0]     word_s;
  logic           is_comma_s;
  logic           boundary_s;

  // Current byte window, including the bit sampled on this edge
  always_comb begin
    word_s     = {shreg_r[6:0], data_in};
    is_comma_s = (word_s == COMMA);
    boundary_s = (bit_cnt_r == 3'd7);
    bc_inc_s   = bc_cnt_r + BCW'(1);
  end

  // State register
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_r <= ST_SEARCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic, including the bit-phase and comma counters
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
    bc_cnt_nxt_s  = bc_cnt_r;
    case (state_r)
      ST_SEARCH: begin
        if (is_comma_s) begin
          // A hit fixes the byte phase: this edge held the comma's LSB
          bit_cnt_nxt_s = 3'd0;
          bc_cnt_nxt_s  = BCW'(1);
          if (BC_COUNT == 1) begin
            state_nxt_s = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_ALIGN;
          end
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      ST_ALIGN: begin
        if (boundary_s) begin
          if (is_comma_s) begin
            bc_cnt_nxt_s = bc_inc_s;
            if (bc_inc_s == BCW'(BC_COUNT)) begin
              state_nxt_s = ST_ACTIVE;
            end else begin
              state_nxt_s = ST_ALIGN;
            end
          end else begin
            // Straddling false hit or broken idle run: hunt again
            bc_cnt_nxt_s = {BCW{1'b0}};
            state_nxt_s  = ST_SEARCH;
          end
        end else begin
          state_nxt_s = ST_ALIGN;
        end
      end
      ST_ACTIVE: begin
        state_nxt_s = ST_ACTIVE;
      end
      default: begin
        state_nxt_s   = ST_SEARCH;
        bit_cnt_nxt_s = 3'd0;
        bc_cnt_nxt_s  = {BCW{1'b0}};
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    data_out_nxt_s  = data_out_r;
    valid_out_nxt_s = valid_out_r;
    active_nxt_s    = (state_nxt_s == ST_ACTIVE);
    case (state_r)
      ST_ACTIVE: begin
        if (boundary_s) begin
          if (is_comma_s) begin
            // Idle byte: drop valid, keep the last payload visible
            valid_out_nxt_s = 1'b0;
          end else begin
            data_out_nxt_s  = word_s;
            valid_out_nxt_s = 1'b1;
          end
        end else begin
          valid_out_nxt_s = valid_out_r;
        end
      end
      ST_SEARCH, ST_ALIGN: begin
        valid_out_nxt_s = 1'b0;
      end
      default: begin
        valid_out_nxt_s = 1'b0;
      end
    endcase
  end

  // Shift register and byte-phase / comma counters
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shreg_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      bc_cnt_r  <= {BCW{1'b0}};
    end else begin
      shreg_r   <= word_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      bc_cnt_r  <= bc_cnt_nxt_s;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_out_r  <= 8'h00;
      valid_out_r <= 1'b0;
      active_r    <= 1'b0;
    end else begin
      data_out_r  <= data_out_nxt_s;
      valid_out_r <= valid_out_nxt_s;
      active_r    <= active_nxt_s;
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign active    = active_r;

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Scoreboard bench for serial_parallel_rx. The driver shifts bits and runs a
// bit-position reference model that queues expected lock times and payload
// bytes. A monitor on the falling edge pops and compares these whenever the
// DUT raises active or presents a byte.

module tb_serial_parallel_rx;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam int         BC_COUNT = 4;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  serial_parallel_rx #(.COMMA(COMMA), .BC_COUNT(BC_COUNT)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  int   checks   = 0;
  int   errors   = 0;
  int   cur_edge = 0;
  exp_t byte_q[$];
  int   act_q[$];

  // Reference model state: positions are bit indices since reset release
  logic [7:0] m_win;
  int         m_n;
  int         m_anchor;
  int         m_hits;
  bit         m_locked;
  int         m_lock_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cur_edge);
    end
  endtask

  task automatic model_reset();
    m_win      = 8'h00;
    m_n        = 0;
    m_anchor   = -1;
    m_hits     = 0;
    m_locked   = 1'b0;
    m_lock_pos = 0;
  endtask

  // Lock = a comma at some position p followed by commas at p+8, p+16, ...
  // until BC_COUNT are seen; afterwards every 8th position carries a byte.
  task automatic model_bit(input logic b);
    int pos;
    m_win = {m_win[6:0], b};
    pos   = m_n;
    m_n++;
    if (m_locked) begin
      if (pos > m_lock_pos && ((pos - m_lock_pos) % 8) == 0 && m_win != COMMA)
        byte_q.push_back('{cyc: cur_edge, data: m_win});
    end else if (m_anchor < 0) begin
      if (m_win == COMMA) begin
        m_anchor = pos;
        m_hits   = 1;
      end
    end else if (((pos - m_anchor) % 8) == 0) begin
      if (m_win == COMMA) begin
        m_hits++;
        if (m_hits == BC_COUNT) begin
          m_locked   = 1'b1;
          m_lock_pos = pos;
          act_q.push_back(cur_edge);
        end
      end else begin
        m_anchor = -1;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    cur_edge++;
    if (reset) model_bit(b);
    @(negedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Idle is encoded as a comma, as the upstream serialiser does
  task automatic tx_send(input bit vld, input logic [7:0] v);
    if (vld) send_byte(v);
    else     send_byte(COMMA);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    chk("async_reset_data", {24'd0, data_out}, 32'h0);
    chk("async_reset_valid", {31'd0, valid_out}, 32'h0);
    chk("async_reset_active", {31'd0, active}, 32'h0);
    chk("byte_q_drained", byte_q.size(), 32'd0);
    chk("act_q_drained", act_q.size(), 32'd0);
    byte_q.delete();
    act_q.delete();
    model_reset();
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
    reset = 1'b1;
  endtask

  // Monitor: consumes expected events when the DUT presents them
  int         rc       = 0;
  bit         prev_act = 1'b0;
  logic [7:0] last_pay = 8'h00;
  always @(negedge clk_32f) begin
    exp_t e;
    int   ea;
    if (!reset) begin
      chk("in_reset_outputs", {22'd0, data_out, valid_out, active}, 32'h0);
      rc       = 0;
      prev_act = 1'b0;
      last_pay = 8'h00;
    end else begin
      if (active && !prev_act) begin
        if (act_q.size() == 0) begin
          chk("active_rise_unexpected", 32'd1, 32'd0);
        end else begin
          ea = act_q.pop_front();
          chk("active_rise_edge", cur_edge, ea);
        end
      end
      if (!active && prev_act) chk("active_dropped", 32'd0, 32'd1);
      if (!active) begin
        chk("prelock_valid", {31'd0, valid_out}, 32'h0);
        chk("prelock_data", {24'd0, data_out}, 32'h0);
      end
      if (valid_out) begin
        if (rc == 0 || rc == 8) begin
          if (byte_q.size() == 0) begin
            chk("byte_unexpected", {24'd0, data_out}, 32'hFFFF_FFFF);
          end else begin
            e = byte_q.pop_front();
            chk("byte_data", {24'd0, data_out}, {24'd0, e.data});
            chk("byte_edge", cur_edge, e.cyc);
            last_pay = e.data;
          end
          rc = 1;
        end else begin
          rc++;
        end
      end else begin
        rc = 0;
        if (active) chk("idle_hold", {24'd0, data_out}, {24'd0, last_pay});
      end
      prev_act = active;
    end
  end

  logic [7:0] t3_bytes [5];

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    model_reset();
    #1;
    // T1: reset with random data
    do_reset(3);

    // T2 + T3: lock then payload with an embedded idle
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    chk("t2_active", {31'd0, active}, 32'd1);
    chk("t2_valid", {31'd0, valid_out}, 32'd0);
    t3_bytes = '{8'hFF, 8'hEE, 8'hAA, 8'hBC, 8'hCC};
    for (int i = 0; i < 5; i++) send_byte(t3_bytes[i]);
    chk("t3_last", {24'd0, data_out}, 32'hCC);
    send_byte(COMMA);
    send_byte(COMMA);

    // T4: misaligned start
    do_reset(3);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    chk("t4_active", {31'd0, active}, 32'd1);
    send_byte(8'h5A);
    chk("t4_data", {24'd0, data_out}, 32'h5A);
    send_byte(COMMA);

    // T5: lock failure then retry, followed by random traffic
    do_reset(3);
    for (int i = 0; i < 3; i++) send_byte(COMMA);
    send_byte(8'h55);
    chk("t5_not_active", {31'd0, active}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    chk("t5_active", {31'd0, active}, 32'd1);
    for (int i = 0; i < 30; i++) tx_send(($urandom_range(3) != 0), 8'($urandom));
    send_byte(COMMA);

    // T6: framed stream after random junk, mid-byte reset, relock
    do_reset(3);
    begin
      int nj;
      nj = $urandom_range(15);
      for (int i = 0; i < nj; i++) send_bit(1'($urandom));
    end
    for (int i = 0; i < 6; i++) send_byte(COMMA);
    tx_send(1'b1, 8'hFF);
    tx_send(1'b1, 8'hEE);
    tx_send(1'b1, 8'hAA);
    tx_send(1'b0, 8'h00);
    tx_send(1'b1, 8'hCC);
    for (int i = 0; i < 20; i++) tx_send(1'($urandom), 8'($urandom));
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_reset(2);
    for (int i = 0; i < 4; i++) send_byte(COMMA);
    chk("t6_relock", {31'd0, active}, 32'd1);
    tx_send(1'b1, 8'h3C);
    tx_send(1'b1, 8'h3C);
    tx_send(1'b0, 8'h00);
    send_byte(COMMA);

    chk("end_byte_q_empty", byte_q.size(), 32'd0);
    chk("end_act_q_empty", act_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
